// File: rtl/ts_pkg.sv
// Shared constants, FSM state types and the null-packet byte generator for
// the TS packet buffer / null inserter.
package ts_pkg;

   localparam logic [7:0] TS_SYNC_BYTE   = 8'h47;
   localparam int         TS_PKT_LEN     = 188;
   localparam logic [7:0] TS_NULL_PID_HI = 8'h1F;
   localparam logic [7:0] TS_NULL_PID_LO = 8'hFF;
   localparam logic [7:0] TS_NULL_AFC    = 8'h10;
   localparam logic [7:0] TS_STUFF_BYTE  = 8'hFF;

   typedef enum logic [1:0] {
      WR_HUNT  = 2'd0,
      WR_WRITE = 2'd1,
      WR_DROP  = 2'd2
   } wr_state_t;

   typedef enum logic [1:0] {
      RD_BOUND = 2'd0,
      RD_DATA  = 2'd1,
      RD_NULL  = 2'd2
   } rd_state_t;

   // Null packet: sync, PID 0x1FFF, payload-only AFC, then stuffing.
   function automatic logic [7:0] ts_null_byte(input logic [7:0] idx);
      logic [7:0] b;
      case (idx)
         8'd0:    b = TS_SYNC_BYTE;
         8'd1:    b = TS_NULL_PID_HI;
         8'd2:    b = TS_NULL_PID_LO;
         8'd3:    b = TS_NULL_AFC;
         default: b = TS_STUFF_BYTE;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/ts_buf_dpram.sv
// Simple dual-port byte RAM: one write port, one read port with a
// registered (1-cycle) read.
module ts_buf_dpram #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/ts_null_inserter.sv
// Packet buffer between the scrambler and the J.83 front end: stores whole
// TS packets and fills read gaps with null packets at packet boundaries.
module ts_null_inserter
   import ts_pkg::*;
#(
   parameter int PKT_NUM = 4,
   parameter int PKT_LEN = TS_PKT_LEN
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       ts_i_valid,
   input  logic [7:0]                 ts_i_data,
   input  logic                       j83_rdreq,
   output logic                       ts_o_valid,
   output logic                       ts_o_sync,
   output logic [7:0]                 ts_o_data,
   output logic [$clog2(PKT_NUM):0]   pkt_level,
   output logic                       ovf_pulse,
   output logic                       sync_err,
   output logic                       null_pulse
);

   localparam int                SLOT_W    = $clog2(PKT_NUM);
   localparam int                LVL_W     = SLOT_W + 1;
   localparam int                AW        = SLOT_W + 8;
   localparam logic [7:0]        LAST_BYTE = 8'(PKT_LEN - 1);
   localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(PKT_NUM);

   wr_state_t         wr_state, wr_state_nxt;
   logic [7:0]        wr_byte, wr_byte_nxt;
   logic [SLOT_W-1:0] wr_slot;
   rd_state_t         rd_state, rd_state_nxt;
   logic [7:0]        rd_byte, rd_byte_nxt;
   logic [SLOT_W-1:0] rd_slot;

   logic       wr_en, pkt_commit, ovf_nxt, serr_nxt;
   logic       rd_en, pkt_release, null_nxt, sync_nxt, src_data_nxt;
   logic [7:0] null_byte_nxt;
   logic       src_data_q;
   logic [7:0] null_byte_q;
   logic [7:0] ram_rd_data;

   logic buf_full, has_pkt, is_sync, at_boundary;

   assign buf_full    = (pkt_level == LVL_FULL);
   assign has_pkt     = (pkt_level != '0);
   assign is_sync     = (ts_i_data == TS_SYNC_BYTE);
   assign at_boundary = (wr_state != WR_HUNT) && (wr_byte == 8'd0);

   // Byte 0 decides sync/overflow; DROP only counts, it never writes.
   always_comb begin
      wr_state_nxt = wr_state;
      wr_byte_nxt  = wr_byte;
      wr_en        = 1'b0;
      pkt_commit   = 1'b0;
      ovf_nxt      = 1'b0;
      serr_nxt     = 1'b0;
      if (ts_i_valid) begin
         if (wr_state == WR_HUNT || at_boundary) begin
            if (!is_sync) begin
               if (at_boundary) begin
                  serr_nxt     = 1'b1;
                  wr_state_nxt = WR_HUNT;
                  wr_byte_nxt  = 8'd0;
               end
            end else if (buf_full) begin
               ovf_nxt      = 1'b1;
               wr_state_nxt = WR_DROP;
               wr_byte_nxt  = 8'd1;
            end else begin
               wr_en        = 1'b1;
               wr_state_nxt = WR_WRITE;
               wr_byte_nxt  = 8'd1;
            end
         end else begin
            wr_en = (wr_state == WR_WRITE);
            if (wr_byte == LAST_BYTE) begin
               wr_byte_nxt = 8'd0;
               pkt_commit  = (wr_state == WR_WRITE);
            end else begin
               wr_byte_nxt = wr_byte + 8'd1;
            end
         end
      end
   end

   always_comb begin
      rd_state_nxt  = rd_state;
      rd_byte_nxt   = rd_byte;
      rd_en         = 1'b0;
      pkt_release   = 1'b0;
      null_nxt      = 1'b0;
      sync_nxt      = 1'b0;
      src_data_nxt  = 1'b0;
      null_byte_nxt = 8'h00;
      if (j83_rdreq) begin
         case (rd_state)
            RD_BOUND: begin
               sync_nxt    = 1'b1;
               rd_byte_nxt = 8'd1;
               if (has_pkt) begin
                  rd_state_nxt = RD_DATA;
                  rd_en        = 1'b1;
                  src_data_nxt = 1'b1;
               end else begin
                  rd_state_nxt  = RD_NULL;
                  null_nxt      = 1'b1;
                  null_byte_nxt = ts_null_byte(8'd0);
               end
            end
            RD_DATA: begin
               rd_en        = 1'b1;
               src_data_nxt = 1'b1;
               if (rd_byte == LAST_BYTE) begin
                  rd_state_nxt = RD_BOUND;
                  rd_byte_nxt  = 8'd0;
                  pkt_release  = 1'b1;
               end else begin
                  rd_byte_nxt = rd_byte + 8'd1;
               end
            end
            RD_NULL: begin
               null_byte_nxt = ts_null_byte(rd_byte);
               if (rd_byte == LAST_BYTE) begin
                  rd_state_nxt = RD_BOUND;
                  rd_byte_nxt  = 8'd0;
               end else begin
                  rd_byte_nxt = rd_byte + 8'd1;
               end
            end
            default: begin
               rd_state_nxt = RD_BOUND;
               rd_byte_nxt  = 8'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_state  <= WR_HUNT;
         wr_byte   <= 8'd0;
         wr_slot   <= '0;
         rd_state  <= RD_BOUND;
         rd_byte   <= 8'd0;
         rd_slot   <= '0;
         pkt_level <= '0;
      end else begin
         wr_state <= wr_state_nxt;
         wr_byte  <= wr_byte_nxt;
         rd_state <= rd_state_nxt;
         rd_byte  <= rd_byte_nxt;
         if (pkt_commit) begin
            wr_slot <= wr_slot + SLOT_W'(1);
         end
         if (pkt_release) begin
            rd_slot <= rd_slot + SLOT_W'(1);
         end
         case ({pkt_commit, pkt_release})
            2'b10:   pkt_level <= pkt_level + LVL_W'(1);
            2'b01:   pkt_level <= pkt_level - LVL_W'(1);
            default: pkt_level <= pkt_level;
         endcase
      end
   end

   // Null bytes are registered so they line up with the RAM read latency.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ts_o_valid  <= 1'b0;
         ts_o_sync   <= 1'b0;
         src_data_q  <= 1'b0;
         null_byte_q <= 8'h00;
         ovf_pulse   <= 1'b0;
         sync_err    <= 1'b0;
         null_pulse  <= 1'b0;
      end else begin
         ts_o_valid  <= j83_rdreq;
         ts_o_sync   <= sync_nxt;
         src_data_q  <= src_data_nxt;
         null_byte_q <= null_byte_nxt;
         ovf_pulse   <= ovf_nxt;
         sync_err    <= serr_nxt;
         null_pulse  <= null_nxt;
      end
   end

   assign ts_o_data = ts_o_valid ? (src_data_q ? ram_rd_data : null_byte_q) : 8'h00;

   ts_buf_dpram #(
      .DEPTH (PKT_NUM * 256),
      .AW    (AW)
   ) u_buf (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr ({wr_slot, wr_byte}),
      .wr_data (ts_i_data),
      .rd_en   (rd_en),
      .rd_addr ({rd_slot, rd_byte}),
      .rd_data (ram_rd_data)
   );

endmodule

// File: tb/tb_ts_null_inserter.sv
// Randomized scoreboard bench for ts_null_inserter against a packet-queue
// reference model.
module tb_ts_null_inserter;

   localparam int PKT_NUM = 4;
   localparam int PKT_LEN = 188;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ts_i_valid;
   logic [7:0] ts_i_data;
   logic       j83_rdreq;
   logic       ts_o_valid;
   logic       ts_o_sync;
   logic [7:0] ts_o_data;
   logic [2:0] pkt_level;
   logic       ovf_pulse;
   logic       sync_err;
   logic       null_pulse;

   always #5 clk = ~clk;

   ts_null_inserter #(
      .PKT_NUM (PKT_NUM),
      .PKT_LEN (PKT_LEN)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ts_i_valid (ts_i_valid),
      .ts_i_data  (ts_i_data),
      .j83_rdreq  (j83_rdreq),
      .ts_o_valid (ts_o_valid),
      .ts_o_sync  (ts_o_sync),
      .ts_o_data  (ts_o_data),
      .pkt_level  (pkt_level),
      .ovf_pulse  (ovf_pulse),
      .sync_err   (sync_err),
      .null_pulse (null_pulse)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state: committed packets as a flat byte stream, the
   // packet currently being output, and the packet being assembled.
   logic [7:0] pq_bytes[$];
   logic [7:0] cur[$];
   bit         cur_data = 1'b0;
   logic [7:0] wbuf[$];
   int         wr_mode = 0;
   int         drop_cnt = 0;
   logic [8:0] exp_q[$];
   int exp_ovf = 0, exp_serr = 0, exp_null = 0;
   int obs_ovf = 0, obs_serr = 0, obs_null = 0;
   int rq_mode = 0;
   int cyc = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic logic [7:0] nullByte(input int i);
      logic [7:0] hdr[4] = '{8'h47, 8'h1F, 8'hFF, 8'h10};
      return (i < 4) ? hdr[i] : 8'hFF;
   endfunction

   function automatic int modelLevel();
      return pq_bytes.size() / PKT_LEN + ((cur_data && cur.size() > 0) ? 1 : 0);
   endfunction

   task automatic startPacket(input logic [7:0] d, input int lvl0);
      if (lvl0 == PKT_NUM) begin
         exp_ovf++;
         wr_mode  = 2;
         drop_cnt = 1;
      end else begin
         wbuf.delete();
         wbuf.push_back(d);
         wr_mode = 1;
      end
   endtask

   task automatic boundaryByte(input logic [7:0] d, input int lvl0);
      if (d != 8'h47) begin
         exp_serr++;
         wr_mode = 0;
      end else begin
         startPacket(d, lvl0);
      end
   endtask

   // One clock of the model; reads happen against the level and packet
   // queue as they stood before this edge.
   task automatic modelStep();
      int lvl0;
      bit first;
      logic [7:0] b;
      if (!rst_n) begin
         pq_bytes.delete();
         cur.delete();
         wbuf.delete();
         cur_data = 1'b0;
         wr_mode  = 0;
         drop_cnt = 0;
      end else begin
         lvl0 = modelLevel();
         if (j83_rdreq) begin
            if (cur.size() == 0) begin
               if (pq_bytes.size() >= PKT_LEN) begin
                  for (int i = 0; i < PKT_LEN; i++) cur.push_back(pq_bytes.pop_front());
                  cur_data = 1'b1;
               end else begin
                  for (int i = 0; i < PKT_LEN; i++) cur.push_back(nullByte(i));
                  cur_data = 1'b0;
                  exp_null++;
               end
            end
            first = (cur.size() == PKT_LEN);
            b = cur.pop_front();
            exp_q.push_back({first, b});
         end
         if (ts_i_valid) begin
            case (wr_mode)
               0: if (ts_i_data == 8'h47) startPacket(ts_i_data, lvl0);
               1: begin
                  if (wbuf.size() == 0) begin
                     boundaryByte(ts_i_data, lvl0);
                  end else begin
                     wbuf.push_back(ts_i_data);
                     if (wbuf.size() == PKT_LEN) begin
                        foreach (wbuf[i]) pq_bytes.push_back(wbuf[i]);
                        wbuf.delete();
                     end
                  end
               end
               default: begin
                  if (drop_cnt == PKT_LEN) boundaryByte(ts_i_data, lvl0);
                  else drop_cnt++;
               end
            endcase
         end
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
      ts_i_valid = v;
      ts_i_data  = d;
      j83_rdreq  = r;
      @(posedge clk);
      modelStep();
      #1;
      checkOutput("pkt_level", pkt_level, modelLevel());
   endtask

   task automatic stepByte(input logic v, input logic [7:0] d);
      logic r;
      case (rq_mode)
         0:       r = 1'b0;
         1:       r = 1'b1;
         2:       r = cyc[0];
         default: r = 1'($urandom_range(0, 1));
      endcase
      cyc++;
      applyStimulus(v, d, r);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) stepByte(1'b0, 8'($urandom_range(0, 255)));
   endtask

   task automatic writePacket(input logic [7:0] idx, input bit bad, input int gapPct);
      logic [7:0] b;
      for (int i = 0; i < PKT_LEN; i++) begin
         if (i == 0) b = bad ? 8'h48 : 8'h47;
         else if (i == 1) b = idx;
         else begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'h47) b = 8'h46;
         end
         while ($urandom_range(0, 99) < gapPct) stepByte(1'b0, 8'($urandom_range(0, 255)));
         stepByte(1'b1, b);
      end
   endtask

   task automatic drainRead();
      rq_mode = 1;
      for (int k = 0; k < 20000 && (modelLevel() > 0 || cur.size() > 0); k++) idle(1);
      rq_mode = 0;
      idle(2);
      checkOutput("drain pkt_level", pkt_level, 0);
      checkOutput("scoreboard leftover", exp_q.size(), 0);
   endtask

   task automatic checkPulses();
      @(negedge clk);
      #1;
      checkOutput("ovf_pulse count", obs_ovf, exp_ovf);
      checkOutput("sync_err count", obs_serr, exp_serr);
      checkOutput("null_pulse count", obs_null, exp_null);
   endtask

   task automatic doReset(input int n);
      rst_n = 1'b0;
      for (int i = 0; i < n; i++) stepByte(1'b1, 8'h47);
      checkOutput("reset ts_o_valid", ts_o_valid, 0);
      checkOutput("reset ts_o_sync", ts_o_sync, 0);
      checkOutput("reset ts_o_data", ts_o_data, 0);
      checkOutput("reset pulses", {ovf_pulse, sync_err, null_pulse}, 0);
      rst_n = 1'b1;
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a byte.
   always @(negedge clk) begin
      logic [8:0] e;
      if (ovf_pulse === 1'b1) obs_ovf++;
      if (sync_err === 1'b1) obs_serr++;
      if (null_pulse === 1'b1) obs_null++;
      if (ts_o_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checkOutput("spurious ts_o_valid", ts_o_valid, 0);
         end else begin
            e = exp_q.pop_front();
            checkOutput("ts_o_data", ts_o_data, e[7:0]);
            checkOutput("ts_o_sync", ts_o_sync, e[8]);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int idx;
      rst_n      = 1'b0;
      ts_i_valid = 1'b0;
      ts_i_data  = 8'h00;
      j83_rdreq  = 1'b0;
      rq_mode    = 1;
      doReset(3);

      // Empty buffer with continuous requests: null packets only.
      rq_mode = 1;
      idle(3 * PKT_LEN + 20);
      rq_mode = 0;
      idle(PKT_LEN);
      checkPulses();

      // Three packets buffered, then read out in order.
      for (int p = 1; p <= 3; p++) writePacket(8'(p), 1'b0, 0);
      checkOutput("three buffered", pkt_level, 3);
      drainRead();
      checkPulses();

      // Five packets into a four-packet buffer: one overflow.
      for (int p = 1; p <= 5; p++) writePacket(8'(p + 8), 1'b0, 10);
      checkOutput("buffer full", pkt_level, PKT_NUM);
      checkPulses();
      drainRead();

      // Corrupted sync on packet 2 of 3.
      for (int p = 1; p <= 3; p++) writePacket(8'(p + 16), p == 2, 0);
      checkOutput("after sync error", pkt_level, 2);
      checkPulses();
      drainRead();

      // Toggling read request while packets commit.
      rq_mode = 2;
      for (int p = 1; p <= 4; p++) writePacket(8'(p + 24), 1'b0, 20);
      drainRead();
      checkPulses();

      // Random mix of gaps, read stalls, corruption and overflow.
      idx = 32;
      rq_mode = 3;
      for (int p = 0; p < 24; p++) begin
         writePacket(8'(idx), $urandom_range(0, 9) == 0, 30);
         idx = (idx + 1) % 64;
         idle($urandom_range(0, 40));
      end
      drainRead();
      checkPulses();

      // Reset mid-write and mid-read, then a clean packet afterwards.
      rq_mode = 0;
      writePacket(8'd50, 1'b0, 0);
      writePacket(8'd51, 1'b0, 0);
      rq_mode = 1;
      idle(40);
      stepByte(1'b1, 8'h47);
      for (int i = 1; i < 60; i++) stepByte(1'b1, 8'(i));
      doReset(1);
      checkOutput("post-reset pkt_level", pkt_level, 0);
      rq_mode = 0;
      writePacket(8'd52, 1'b0, 5);
      checkOutput("post-reset one packet", pkt_level, 1);
      drainRead();
      checkPulses();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
